// File: rtl/shift_pkg.sv
// Shared widths, FSM/direction encodings and bit-reverse helper for shift_arb.
// Latency: none (package). Backpressure: n/a.
package shift_pkg;

   localparam int DW = 32;
   localparam int SW = 5;

   typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;
   typedef enum logic {LEFT = 1'b0, RIGHT = 1'b1} dir_e;

   function automatic logic [DW-1:0] bitrev(input logic [DW-1:0] x);
      logic [DW-1:0] r;
      r = '0;
      for (int i = 0; i < DW; i++) r[i] = x[DW-1-i];
      return r;
   endfunction

endpackage

// File: rtl/shift_core.sv
// Logarithmic left shifter: one 2:1 mux stage per shift-amount bit.
// Latency: 0 (combinational). Backpressure: none.
module shift_core #(
   parameter int DW = shift_pkg::DW,
   parameter int SW = shift_pkg::SW
) (
   input  logic [DW-1:0] data,
   input  logic [SW-1:0] amt,
   output logic [DW-1:0] res
);

   logic [DW-1:0] stg [0:SW];

   assign stg[0] = data;

   for (genvar i = 0; i < SW; i++) begin : g_stage
      assign stg[i+1] = amt[i] ? (stg[i] << (1 << i)) : stg[i];
   end

   assign res = stg[SW];

endmodule

// File: rtl/shift_arb.sv
// Two requesters round-robin arbitrated onto one shifter; right shifts when SHIFT_ARB_RIGHT_EN is defined.
// Latency: 1 cycle. Backpressure: in*_ready low while result held and out_ready low.
module shift_arb #(
   parameter int DW = shift_pkg::DW,
   parameter int SW = shift_pkg::SW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          in0_valid,
   output logic          in0_ready,
   input  logic [DW-1:0] in0_data,
   input  logic [SW-1:0] in0_amt,
   input  logic          in0_dir,
   input  logic          in1_valid,
   output logic          in1_ready,
   input  logic [DW-1:0] in1_data,
   input  logic [SW-1:0] in1_amt,
   input  logic          in1_dir,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [DW-1:0] out_res,
   output logic          out_id
);

   import shift_pkg::*;

   state_e        state_q;
   logic [DW-1:0] res_q;
   logic          id_q;
   logic          ptr_q;

   logic          can_accept;
   logic          gnt1;
   logic          accept;
   logic [DW-1:0] sel_dat;
   logic [SW-1:0] sel_amt;
   logic [DW-1:0] core_in;
   logic [DW-1:0] core_res;
   logic [DW-1:0] res_d;

   assign out_valid  = (state_q == FULL);
   assign out_res    = res_q;
   assign out_id     = id_q;
   assign can_accept = !out_valid | out_ready;

   // Pointer only matters when both requesters compete.
   assign gnt1      = in1_valid & (!in0_valid | ptr_q);
   assign in0_ready = rst_n & can_accept & in0_valid & !gnt1;
   assign in1_ready = rst_n & can_accept & gnt1;
   assign accept    = in0_ready | in1_ready;

   assign sel_dat = gnt1 ? in1_data : in0_data;
   assign sel_amt = gnt1 ? in1_amt  : in0_amt;

`ifdef SHIFT_ARB_RIGHT_EN
   dir_e sel_dir;
   assign sel_dir = dir_e'(gnt1 ? in1_dir : in0_dir);
   // Right shift reuses the left shifter by mirroring operand and result.
   assign core_in = (sel_dir == RIGHT) ? bitrev(sel_dat) : sel_dat;
   assign res_d   = (sel_dir == RIGHT) ? bitrev(core_res) : core_res;
`else
   logic unused_dir;
   assign unused_dir = in0_dir ^ in1_dir;
   assign core_in    = sel_dat;
   assign res_d      = core_res;
`endif

   shift_core #(.DW(DW), .SW(SW)) u_core (
      .data (core_in),
      .amt  (sel_amt),
      .res  (core_res)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         res_q   <= '0;
         id_q    <= 1'b0;
         ptr_q   <= 1'b0;
      end else begin
         case (state_q)
            EMPTY: begin
               if (accept) begin
                  state_q <= FULL;
                  res_q   <= res_d;
                  id_q    <= gnt1;
                  ptr_q   <= !gnt1;
               end
            end
            FULL: begin
               if (accept) begin
                  res_q <= res_d;
                  id_q  <= gnt1;
                  ptr_q <= !gnt1;
               end else if (out_ready) begin
                  state_q <= EMPTY;
               end
            end
            default: state_q <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_shift_arb.sv
// Directed table-driven bench for shift_arb plus hand-written stall and reset sequences.
module tb_shift_arb;

   logic        clk;
   logic        rst_n;
   logic        in0_valid, in1_valid;
   logic        in0_ready, in1_ready;
   logic [31:0] in0_data, in1_data;
   logic [4:0]  in0_amt, in1_amt;
   logic        in0_dir, in1_dir;
   logic        out_valid, out_ready;
   logic [31:0] out_res;
   logic        out_id;

   int n_chk  = 0;
   int n_fail = 0;

`ifdef SHIFT_ARB_RIGHT_EN
   localparam logic [31:0] R1 = 32'h0800_0000;
   localparam logic [31:0] R2 = 32'h00F0_0000;
`else
   localparam logic [31:0] R1 = 32'h0000_0000;
   localparam logic [31:0] R2 = 32'h0000_0F00;
`endif

   typedef struct {
      logic        v0;
      logic [31:0] d0;
      logic [4:0]  a0;
      logic        r0;
      logic        v1;
      logic [31:0] d1;
      logic [4:0]  a1;
      logic        r1;
      logic        ordy;
      logic        e_rdy0;
      logic        e_rdy1;
      logic        e_ov;
      logic [31:0] e_res;
      logic        e_id;
   } vec_t;

   localparam int NV = 15;
   vec_t vecs [NV];

   shift_arb dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (in0_valid),
      .in0_ready (in0_ready),
      .in0_data  (in0_data),
      .in0_amt   (in0_amt),
      .in0_dir   (in0_dir),
      .in1_valid (in1_valid),
      .in1_ready (in1_ready),
      .in1_data  (in1_data),
      .in1_amt   (in1_amt),
      .in1_dir   (in1_dir),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_res   (out_res),
      .out_id    (out_id)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic drive(input vec_t v);
      in0_valid = v.v0; in0_data = v.d0; in0_amt = v.a0; in0_dir = v.r0;
      in1_valid = v.v1; in1_data = v.d1; in1_amt = v.a1; in1_dir = v.r1;
      out_ready = v.ordy;
   endtask

   initial begin
      // both-valid operands: in0 0xF0<<4 = 0xF00, in1 0x1<<1 = 0x2
      vecs[0]  = '{1'b1, 32'h0000_0001, 5'd31, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 1'b0};
      vecs[1]  = '{1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 32'h8000_0000, 5'd4, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, R1, 1'b1};
      vecs[2]  = '{1'b1, 32'h0000_00F0, 5'd4, 1'b0, 1'b1, 32'h0000_0001, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0F00, 1'b0};
      vecs[3]  = '{1'b1, 32'h0000_00F0, 5'd4, 1'b0, 1'b1, 32'h0000_0001, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0002, 1'b1};
      vecs[4]  = '{1'b1, 32'h0000_00F0, 5'd4, 1'b0, 1'b1, 32'h0000_0001, 5'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h0000_0F00, 1'b0};
      vecs[5]  = '{1'b1, 32'h0000_00F0, 5'd4, 1'b0, 1'b1, 32'h0000_0001, 5'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0002, 1'b1};
      vecs[6]  = '{1'b0, 32'h0, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0};
      vecs[7]  = '{1'b1, 32'hDEAD_BEEF, 5'd0, 1'b0, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'hDEAD_BEEF, 1'b0};
      vecs[8]  = '{1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 32'hF000_000F, 5'd8, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_0F00, 1'b1};
      vecs[9]  = '{1'b1, 32'hF000_000F, 5'd8, 1'b1, 1'b0, 32'h0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, R2, 1'b0};
      // three stalled cycles: result held, nothing accepted
      vecs[10] = '{1'b1, 32'h1234_5678, 5'd1, 1'b0, 1'b1, 32'h0000_0003, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, R2, 1'b0};
      vecs[11] = '{1'b1, 32'h1234_5678, 5'd1, 1'b0, 1'b1, 32'h0000_0003, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, R2, 1'b0};
      vecs[12] = '{1'b1, 32'h1234_5678, 5'd1, 1'b0, 1'b1, 32'h0000_0003, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, R2, 1'b0};
      vecs[13] = '{1'b1, 32'h1234_5678, 5'd1, 1'b0, 1'b1, 32'h0000_0003, 5'd2, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0000_000C, 1'b1};
      vecs[14] = '{1'b1, 32'h1234_5678, 5'd1, 1'b0, 1'b1, 32'h0000_0003, 5'd2, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 32'h2468_ACF0, 1'b0};

      rst_n = 1'b0;
      in0_valid = 1'b1; in0_data = '0; in0_amt = '0; in0_dir = 1'b0;
      in1_valid = 1'b0; in1_data = '0; in1_amt = '0; in1_dir = 1'b0;
      out_ready = 1'b1;
      #12;
      check("reset out_valid", {31'b0, out_valid}, 32'd0);
      check("reset out_res", out_res, 32'd0);
      check("reset out_id", {31'b0, out_id}, 32'd0);
      check("reset in0_ready", {31'b0, in0_ready}, 32'd0);
      check("reset in1_ready", {31'b0, in1_ready}, 32'd0);
      in0_valid = 1'b0;
      #6 rst_n = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < NV; i++) begin
         drive(vecs[i]);
         #3;
         check($sformatf("v%0d in0_ready", i), {31'b0, in0_ready}, {31'b0, vecs[i].e_rdy0});
         check($sformatf("v%0d in1_ready", i), {31'b0, in1_ready}, {31'b0, vecs[i].e_rdy1});
         @(posedge clk);
         #1;
         check($sformatf("v%0d out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].e_ov});
         if (vecs[i].e_ov) begin
            check($sformatf("v%0d out_res", i), out_res, vecs[i].e_res);
            check($sformatf("v%0d out_id", i), {31'b0, out_id}, {31'b0, vecs[i].e_id});
         end
      end

      // Mid-cycle reset while FULL with the pointer at 1.
      #2 rst_n = 1'b0;
      #1;
      check("async rst out_valid", {31'b0, out_valid}, 32'd0);
      check("async rst out_res", out_res, 32'd0);
      check("async rst out_id", {31'b0, out_id}, 32'd0);
      check("async rst in0_ready", {31'b0, in0_ready}, 32'd0);
      check("async rst in1_ready", {31'b0, in1_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("rst held out_valid", {31'b0, out_valid}, 32'd0);
      #2 rst_n = 1'b1;
      #1;
      check("post rst in0_ready", {31'b0, in0_ready}, 32'd1);
      check("post rst in1_ready", {31'b0, in1_ready}, 32'd0);
      @(posedge clk);
      #1;
      check("post rst out_valid", {31'b0, out_valid}, 32'd1);
      check("post rst out_id", {31'b0, out_id}, 32'd0);
      check("post rst out_res", out_res, 32'h2468_ACF0);
      @(posedge clk);
      #1;
      check("post rst 2nd out_id", {31'b0, out_id}, 32'd1);
      check("post rst 2nd out_res", out_res, 32'h0000_000C);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/shift_arb.md
SHIFT_ARB -- requirements
Module: shift_arb

Interface
REQ-001 SHALL have parameter DW, default 32, datapath width in bits (only 32 supported).
REQ-002 SHALL have parameter SW, default 5, shift-amount width in bits (log2 DW).
REQ-003 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports in0_valid/in1_valid, input, 1 each, requester operation offered.
REQ-006 SHALL have ports in0_ready/in1_ready, output, 1 each, requester operation accepted this cycle.
REQ-007 SHALL have ports in0_data/in1_data, input, DW each, operand.
REQ-008 SHALL have ports in0_amt/in1_amt, input, SW each, shift amount 0..31.
REQ-009 SHALL have ports in0_dir/in1_dir, input, 1 each, 0 = logical left, 1 = logical right.
REQ-010 SHALL have port out_valid, output, 1, result held valid.
REQ-011 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-012 SHALL have port out_res, output, DW, shifted result.
REQ-013 SHALL have port out_id, output, 1, index of the requester that owns out_res.

Function
REQ-014 SHALL share one combinational left-shift datapath between the two requesters.
REQ-015 SHALL implement a two-state FSM: EMPTY (out_valid=0) and FULL (out_valid=1).
REQ-016 SHALL define can_accept = !out_valid | out_ready.
REQ-017 SHALL assert at most one of in0_ready/in1_ready per cycle, and only when can_accept=1 and that requester is valid and granted.
REQ-018 SHALL grant the only valid requester when exactly one of in0_valid/in1_valid is high.
REQ-019 SHALL grant the requester named by a 1-bit round-robin pointer when both are valid; reset value of the pointer is 0.
REQ-020 SHALL set the pointer to the non-granted index after every accepted transfer, and leave it unchanged otherwise.
REQ-021 SHALL register out_res, out_id and out_valid=1 on the edge that ends an accepting cycle, giving a latency of exactly 1 cycle.
REQ-022 SHALL compute a right shift by bit-reversing the operand, left-shifting it, and bit-reversing the result; vacated bits are 0.
REQ-023 SHALL pass the operand through unchanged when amt=0.
REQ-024 SHALL hold out_res/out_id stable while out_valid=1 and out_ready=0; no requester is accepted in that cycle.
REQ-025 SHALL, when FULL with out_ready=1 and a requester valid, complete the output transfer and accept the new operation in the same cycle (throughput 1 op/cycle).
REQ-026 SHALL move FULL to EMPTY when out_ready=1 and no requester is valid.
REQ-027 MAY let in*_ready depend combinationally on in*_valid and out_ready; in*_valid SHALL NOT depend on in*_ready.

Reset
REQ-028 SHALL, on rst_n low, immediately clear out_valid, out_res, out_id and the pointer to 0, and drive in0_ready/in1_ready to 0.
REQ-029 SHALL discard any held result when reset is asserted mid-operation; the first accept after deassertion occurs on the first clock edge with rst_n high.

Configuration
REQ-030 SHALL, with SHIFT_ARB_RIGHT_EN defined, honour in*_dir as in REQ-022.
REQ-031 SHALL, without SHIFT_ARB_RIGHT_EN, ignore in*_dir, perform only left shifts, and omit the reversal logic.

Structure
REQ-032 SHALL place DW, SW, the FSM state encoding (EMPTY=0, FULL=1) and the direction encoding (LEFT=0, RIGHT=1) in a shared package shift_pkg.
REQ-033 SHALL instantiate one sub-module, shift_core: a 5-stage, 2:1-mux logarithmic left shifter (data, amt -> res), purely combinational.

Verification
REQ-034 Bench SHALL drive in0: data 0x0000_0001, amt 31, dir 0, out_ready=1 -> next cycle out_valid=1, out_res=0x8000_0000, out_id=0.
REQ-035 Bench SHALL drive in1: data 0x8000_0000, amt 4, dir 1 with the macro defined -> out_res=0x0800_0000, out_id=1; without the macro -> out_res=0x0000_0000.
REQ-036 Bench SHALL hold both requesters valid for 4 cycles with out_ready=1 -> out_id sequence 0,1,0,1 at one result per cycle.
REQ-037 Bench SHALL hold out_ready=0 for 3 cycles while FULL -> out_res stable, in0_ready=in1_ready=0; then out_ready=1 -> pending requester accepted that cycle.
REQ-038 Bench SHALL drive data 0xDEAD_BEEF with amt 0 -> out_res=0xDEAD_BEEF.
REQ-039 Bench SHALL pulse rst_n low while FULL -> out_valid=0 and pointer=0 without waiting for a clock edge; with both requesters valid, the first grant after reset goes to in0.
